// File: rtl/prim_heartbeat_pkg.sv
// Shared types and helpers for the multi-channel heartbeat timeout monitor.
// Optional build macro used by the channel: PRIM_HEARTBEAT_TIMEOUT_MAXGAP_EN.
package prim_heartbeat_pkg;

  localparam int StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    HbIdle    = 2'b00,
    HbArmed   = 2'b01,
    HbRun     = 2'b10,
    HbTimeout = 2'b11
  } hb_state_e;

  // True when a startup grace window is non-zero and fits the counter width.
  function automatic bit hb_startup_ok(input int limit, input int width);
    if (limit <= 0) begin
      return 1'b0;
    end
    if (width >= 31) begin
      return 1'b1;
    end
    return limit < (1 << width);
  endfunction

endpackage

// File: rtl/prim_heartbeat_chan.sv
// One heartbeat channel: toggle detection, IDLE/ARMED/RUN/TIMEOUT FSM, gap counter,
// sticky timeout and entry pulse. Per-channel max-gap statistic is built only when
// PRIM_HEARTBEAT_TIMEOUT_MAXGAP_EN is defined; otherwise max_gap_o is tied to zero.
module prim_heartbeat_chan
  import prim_heartbeat_pkg::*;
#(
  parameter int CntWidth     = 16,
  parameter int StartupLimit = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                hb_i,
  input  logic                clr_i,
  input  logic [CntWidth-1:0] limit_i,
  output logic                timeout_o,
  output logic                timeout_pulse_o,
  output logic [CntWidth-1:0] max_gap_o
);

  // Last count value that is still inside the startup grace window.
  localparam logic [CntWidth-1:0] StartupLast = CntWidth'(StartupLimit - 1);

  hb_state_e           state_reg, state_next;
  logic [CntWidth-1:0] cnt_reg, cnt_next;
  logic                hb_reg;
  logic                seed_reg, seed_next;
  logic                pulse_reg, pulse_next;
  logic                hb_event;
  logic [CntWidth-1:0] run_last;

  // A channel enabled while its heartbeat already sits high owes one event;
  // seed_reg carries it into the first ARMED cycle because hb_reg has already
  // absorbed the level while the channel was idle.
  assign hb_event = (hb_i ^ hb_reg) | seed_reg;

  // Last count inside the runtime window; only meaningful when limit_i != 0.
  assign run_last = limit_i - CntWidth'(1);

  // Next-state and counter logic; priority is !en > clr > event > count.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    seed_next  = 1'b0;
    if (!en_i) begin
      state_next = HbIdle;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        HbIdle: begin
          cnt_next = '0;
          if (!clr_i) begin
            state_next = HbArmed;
            seed_next  = hb_i;
          end
        end
        HbArmed: begin
          if (clr_i) begin
            cnt_next = '0;
          end else if (hb_event) begin
            state_next = HbRun;
            cnt_next   = '0;
          end else if (cnt_reg >= StartupLast) begin
            state_next = HbTimeout;
          end else begin
            cnt_next = cnt_reg + CntWidth'(1);
          end
        end
        HbRun: begin
          if (clr_i) begin
            cnt_next = '0;
          end else if (hb_event) begin
            cnt_next = '0;
          end else if (limit_i == '0) begin
            cnt_next = '0;
          end else if (cnt_reg >= run_last) begin
            // >= rather than == so a lowered limit cannot let cnt run on and wrap.
            state_next = HbTimeout;
          end else begin
            cnt_next = cnt_reg + CntWidth'(1);
          end
        end
        HbTimeout: begin
          if (clr_i) begin
            state_next = HbArmed;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = HbIdle;
          cnt_next   = '0;
        end
      endcase
    end
    pulse_next = (state_next == HbTimeout) && (state_reg != HbTimeout);
  end

  // State, counter, heartbeat history and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= HbIdle;
      cnt_reg   <= '0;
      hb_reg    <= 1'b0;
      seed_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hb_reg    <= hb_i;
      seed_reg  <= seed_next;
      pulse_reg <= pulse_next;
    end
  end

  assign timeout_o       = (state_reg == HbTimeout);
  assign timeout_pulse_o = pulse_reg;

`ifdef PRIM_HEARTBEAT_TIMEOUT_MAXGAP_EN
  logic [CntWidth-1:0] max_reg, max_next;
  logic [CntWidth-1:0] gap_len;
  logic                gap_hit;

  // An event only counts as a gap when it is accepted in RUN (not masked by clr).
  assign gap_hit = en_i && !clr_i && (state_reg == HbRun) && hb_event;
  // Gap length is cnt+1, saturating at all-ones.
  assign gap_len = (&cnt_reg) ? cnt_reg : cnt_reg + CntWidth'(1);

  // Running maximum of observed gaps, cleared by clr or disable.
  always_comb begin
    max_next = max_reg;
    if (!en_i || clr_i) begin
      max_next = '0;
    end else if (gap_hit && (gap_len > max_reg)) begin
      max_next = gap_len;
    end
  end

  // Max-gap statistic register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_reg <= '0;
    end else begin
      max_reg <= max_next;
    end
  end

  assign max_gap_o = max_reg;
`else
  assign max_gap_o = '0;
`endif

endmodule

// File: rtl/prim_heartbeat_timeout.sv
// Multi-channel heartbeat liveness monitor: one prim_heartbeat_chan per channel,
// plus the any-timeout reduction and max-gap bus packing.
// Optional feature macro: PRIM_HEARTBEAT_TIMEOUT_MAXGAP_EN (per-channel max gap).
module prim_heartbeat_timeout
  import prim_heartbeat_pkg::*;
#(
  parameter int NumChan      = 4,
  parameter int CntWidth     = 16,
  parameter int StartupLimit = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumChan-1:0]           en_i,
  input  logic [NumChan-1:0]           hb_i,
  input  logic [CntWidth-1:0]          limit_i,
  input  logic [NumChan-1:0]           clr_i,
  output logic [NumChan-1:0]           timeout_o,
  output logic [NumChan-1:0]           timeout_pulse_o,
  output logic                         any_timeout_o,
  output logic [NumChan*CntWidth-1:0]  max_gap_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NumChan; gi++) begin : g_chan
      prim_heartbeat_chan #(
        .CntWidth     (CntWidth),
        .StartupLimit (StartupLimit)
      ) u_chan (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .en_i            (en_i[gi]),
        .hb_i            (hb_i[gi]),
        .clr_i           (clr_i[gi]),
        .limit_i         (limit_i),
        .timeout_o       (timeout_o[gi]),
        .timeout_pulse_o (timeout_pulse_o[gi]),
        .max_gap_o       (max_gap_o[gi*CntWidth +: CntWidth])
      );
    end
  endgenerate

  assign any_timeout_o = |timeout_o;

  // The grace window must be non-zero and representable in the counter.
  startup_limit_range_a : assert property (@(posedge clk_i)
    hb_startup_ok(StartupLimit, CntWidth));

  // A timeout pulse is only ever emitted alongside the sticky flag.
  pulse_implies_timeout_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (timeout_pulse_o & ~timeout_o) == '0);

endmodule
